// File: rtl/float_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : float_pkg
//  Description : Shared format helpers for the iterative float divider:
//                derived widths, bias, state encoding, flag bit positions and
//                canonical special-value bit patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
package float_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    // Flag vector bit positions: {invalid, div_by_zero, overflow, underflow}
    localparam int FLG_INVALID = 3;
    localparam int FLG_DBZ     = 2;
    localparam int FLG_OVF     = 1;
    localparam int FLG_UNF     = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_NORM   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Full word width {sign, exp, frac}
    function automatic int fmt_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Quotient bits produced: integer, fraction, guard, round and one spare
    function automatic int fmt_qw(input int man_w);
        return man_w + 4;
    endfunction

    function automatic int fmt_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set
    function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    // Infinity magnitude (no sign bit): exponent all ones, fraction zero
    function automatic logic [63:0] inf_bits(input int exp_w, input int man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/float_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : float_unpack
//  Description : Combinational classifier for one IEEE-754-style operand.
//                Subnormals are treated as zero; mantissa carries the
//                hidden one.
//  Revision    : 1.0 - initial release
// ============================================================================
module float_unpack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] x,
    output logic                 sign,
    output logic [EXP_W-1:0]     expo,
    output logic [MAN_W:0]       mant,
    output logic                 is_zero,
    output logic                 is_inf,
    output logic                 is_nan
);

    logic [MAN_W-1:0] w_frac;
    logic             w_exp_ones;

    // Field split and class decode
    always_comb begin
        sign       = x[EXP_W+MAN_W];
        expo       = x[EXP_W+MAN_W-1:MAN_W];
        w_frac     = x[MAN_W-1:0];
        w_exp_ones = &expo;
        mant       = {1'b1, w_frac};
        is_zero    = (expo == '0);
        is_inf     = w_exp_ones && (w_frac == '0);
        is_nan     = w_exp_ones && (w_frac != '0);
    end

endmodule
`default_nettype wire

// File: rtl/float_division_iter.sv
`default_nettype none
// ============================================================================
//  Module      : float_division_iter
//  Description : Sequential floating-point divider. Radix-2 restoring
//                mantissa division (one quotient bit per cycle), RNE
//                rounding, FTZ/DAZ, exception flags, valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module float_division_iter
    import float_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [EXP_W+MAN_W:0]       a,
    input  logic [EXP_W+MAN_W:0]       b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EXP_W+MAN_W:0]       result,
    output logic [3:0]                 flags
);

    localparam int W  = fmt_w(EXP_W, MAN_W);
    localparam int QW = fmt_qw(MAN_W);
    localparam int XW = EXP_W + 2;          // signed working exponent
    localparam int RW = MAN_W + 2;          // remainder stays below 2*divisor
    localparam int CW = $clog2(QW + 1);

    localparam logic [W-1:0]          c_qnan     = W'(qnan_bits(EXP_W, MAN_W));
    localparam logic [W-2:0]          c_inf_mag  = (W-1)'(inf_bits(EXP_W, MAN_W));
    localparam logic signed [XW-1:0]  c_bias     = XW'(fmt_bias(EXP_W));
    localparam logic signed [XW-1:0]  c_exp_max  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0]  c_one      = XW'(1);
    localparam logic signed [XW-1:0]  c_ezero    = '0;
    localparam logic [CW-1:0]         c_last_it  = CW'(QW - 1);

    state_t r_state, w_next_state;

    logic                   r_sign;
    logic signed [XW-1:0]   r_exp;
    logic [RW-1:0]          r_rem;
    logic [MAN_W:0]         r_div;
    logic [QW-1:0]          r_quo;
    logic [CW-1:0]          r_cnt;
    logic [W-1:0]           r_result;
    logic [3:0]             r_flags;

    logic                   w_sa, w_sb, w_za, w_zb, w_ia, w_ib, w_na, w_nb;
    logic [EXP_W-1:0]       w_ea, w_eb;
    logic [MAN_W:0]         w_ma, w_mb;

    float_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .x(a), .sign(w_sa), .expo(w_ea), .mant(w_ma),
        .is_zero(w_za), .is_inf(w_ia), .is_nan(w_na)
    );

    float_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .x(b), .sign(w_sb), .expo(w_eb), .mant(w_mb),
        .is_zero(w_zb), .is_inf(w_ib), .is_nan(w_nb)
    );

    logic                   w_sign_in;
    logic signed [XW-1:0]   w_exp_in;
    logic                   w_spec;
    logic [W-1:0]           w_spec_result;
    logic [3:0]             w_spec_flags;

    // Special-operand detection and their direct results
    always_comb begin
        w_sign_in     = w_sa ^ w_sb;
        w_exp_in      = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + c_bias;
        w_spec        = 1'b1;
        w_spec_result = '0;
        w_spec_flags  = '0;
        if (w_na || w_nb || (w_za && w_zb) || (w_ia && w_ib)) begin
            w_spec_result              = c_qnan;
            w_spec_flags[FLG_INVALID]  = 1'b1;
        end else if (w_ia) begin
            w_spec_result = {w_sign_in, c_inf_mag};
        end else if (w_zb) begin
            w_spec_result          = {w_sign_in, c_inf_mag};
            w_spec_flags[FLG_DBZ]  = 1'b1;
        end else if (w_za || w_ib) begin
            w_spec_result = {w_sign_in, {(W-1){1'b0}}};
        end else begin
            w_spec = 1'b0;
        end
    end

    logic                   w_q_bit;
    logic [RW-1:0]          w_rem_sub;
    logic [RW-1:0]          w_rem_next;

    // One restoring-division step: trial subtract, keep if non-negative
    always_comb begin
        w_q_bit    = (r_rem >= {1'b0, r_div});
        w_rem_sub  = w_q_bit ? (r_rem - {1'b0, r_div}) : r_rem;
        w_rem_next = w_rem_sub << 1;
    end

    logic [QW-1:0]          w_nq;
    logic signed [XW-1:0]   w_nexp;
    logic signed [XW-1:0]   w_rexp;
    logic [MAN_W:0]         w_mant;
    logic [MAN_W:0]         w_mant_r;
    logic                   w_guard, w_rnd, w_sticky, w_up, w_carry;
    logic [W-1:0]           w_norm_result;
    logic [3:0]             w_norm_flags;

    // Normalise, round to nearest even, and range-check the exponent
    always_comb begin
        w_nq          = r_quo[QW-1] ? r_quo : {r_quo[QW-2:0], 1'b0};
        w_nexp        = r_quo[QW-1] ? r_exp : (r_exp - c_one);
        w_mant        = w_nq[QW-1:3];
        w_guard       = w_nq[2];
        w_rnd         = w_nq[1];
        w_sticky      = w_nq[0] | (r_rem != '0);
        w_up          = w_guard & (w_rnd | w_sticky | w_mant[0]);
        w_mant_r      = w_mant + {{MAN_W{1'b0}}, w_up};
        // Mantissa starts with its MSB set, so a cleared MSB after the
        // increment can only mean it wrapped: value is exactly 2.0
        w_carry       = ~w_mant_r[MAN_W];
        w_rexp        = w_carry ? (w_nexp + c_one) : w_nexp;
        w_norm_flags  = '0;
        w_norm_result = {r_sign, w_rexp[EXP_W-1:0], w_mant_r[MAN_W-1:0]};
        if (w_rexp >= c_exp_max) begin
            w_norm_result          = {r_sign, c_inf_mag};
            w_norm_flags[FLG_OVF]  = 1'b1;
        end else if (w_rexp <= c_ezero) begin
            w_norm_result          = {r_sign, {(W-1){1'b0}}};
            w_norm_flags[FLG_UNF]  = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = w_spec ? ST_DONE : ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                if (r_cnt == c_last_it) begin
                    w_next_state = ST_NORM;
                end
            end
            ST_NORM: begin
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result registration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sign <= w_sign_in;
                        if (w_spec) begin
                            r_result <= w_spec_result;
                            r_flags  <= w_spec_flags;
                        end else begin
                            r_exp <= w_exp_in;
                            r_rem <= {1'b0, w_ma};
                            r_div <= w_mb;
                            r_quo <= '0;
                            r_cnt <= '0;
                        end
                    end
                end
                ST_DIVIDE: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[QW-2:0], w_q_bit};
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_NORM: begin
                    r_result <= w_norm_result;
                    r_flags  <= w_norm_flags;
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign flags  = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_float_division_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_float_division_iter
//  Description : Self-checking bench for float_division_iter (single and
//                half precision instances) with directed vectors, handshake
//                and reset corner sequences, and randomized operands checked
//                against an integer-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_float_division_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv32, ir32, ov32, or32;
    logic [31:0] a32, b32, res32;
    logic [3:0]  fl32;
    logic        iv16, ir16, ov16, or16;
    logic [15:0] a16, b16, res16;
    logic [3:0]  fl16;

    float_division_iter dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .out_valid(ov32), .out_ready(or32),
        .result(res32), .flags(fl32)
    );

    float_division_iter #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16),
        .result(res16), .flags(fl16)
    );

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        bit          h;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    function automatic logic get_ov(input bit h);
        return h ? ov16 : ov32;
    endfunction
    function automatic logic get_ir(input bit h);
        return h ? ir16 : ir32;
    endfunction
    function automatic logic [31:0] get_res(input bit h);
        return h ? {16'h0, res16} : res32;
    endfunction
    function automatic logic [3:0] get_fl(input bit h);
        return h ? fl16 : fl32;
    endfunction

    // Reference: exact rational quotient, round-to-nearest-even via remainder
    function automatic void ref_div(input int e, input int m,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic [3:0] fl,
                                    output bit spec);
        longint one   = 1;
        longint emax  = (one << e) - 1;
        longint bias  = (one << (e - 1)) - 1;
        longint fmask = (one << m) - 1;
        longint av = longint'(a);
        longint bv = longint'(b);
        longint ea = (av >> m) & emax, eb = (bv >> m) & emax;
        longint fa = av & fmask, fb = bv & fmask;
        longint s  = ((av >> (e + m)) ^ (bv >> (e + m))) & 1;
        longint sbit = s << (e + m);
        longint infw = sbit | (emax << m);
        bit za = (ea == 0), zb = (eb == 0);
        bit ia = (ea == emax) && (fa == 0), ib = (eb == emax) && (fb == 0);
        bit na = (ea == emax) && (fa != 0), nb = (eb == emax) && (fb != 0);
        longint ma, mb, ex, num, q, r;
        fl = 4'h0;
        spec = 1'b1;
        if (na || nb || (za && zb) || (ia && ib)) begin
            res = 32'((emax << m) | (one << (m - 1)));
            fl  = 4'h8;
        end else if (ia) begin
            res = 32'(infw);
        end else if (zb) begin
            res = 32'(infw);
            fl  = 4'h4;
        end else if (za || ib) begin
            res = 32'(sbit);
        end else begin
            spec = 1'b0;
            ma = (one << m) | fa;
            mb = (one << m) | fb;
            ex = ea - eb + bias;
            if (ma >= mb) begin
                num = ma << m;
            end else begin
                num = ma << (m + 1);
                ex  = ex - 1;
            end
            q = num / mb;
            r = num % mb;
            if ((2 * r > mb) || ((2 * r == mb) && ((q & 1) == 1))) q = q + 1;
            if (q == (one << (m + 1))) begin
                q  = q >> 1;
                ex = ex + 1;
            end
            if (ex >= emax) begin
                res = 32'(infw);
                fl  = 4'h2;
            end else if (ex <= 0) begin
                res = 32'(sbit);
                fl  = 4'h1;
            end else begin
                res = 32'(sbit | (ex << m) | (q & fmask));
            end
        end
    endfunction

    // Issue one operation, measure edges from accept to out_valid, check, consume
    task automatic do_op(input bit h, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic [3:0] exp_fl,
                         input int exp_lat, input string name);
        int n;
        @(negedge clk);
        if (h) begin
            a16 = a[15:0]; b16 = b[15:0]; iv16 = 1'b1;
        end else begin
            a32 = a; b32 = b; iv32 = 1'b1;
        end
        check({name, " in_ready"}, 32'(get_ir(h)), 32'd1);
        @(posedge clk); #1;
        iv16 = 1'b0;
        iv32 = 1'b0;
        n = 0;
        while (!get_ov(h) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_err++;
            $display("FAIL %s timeout: out_valid not seen within 100 cycles", name);
        end else begin
            if (exp_lat >= 0) check({name, " latency"}, 32'(n), 32'(exp_lat));
            check({name, " result"}, get_res(h), exp_res);
            check({name, " flags"}, 32'(get_fl(h)), 32'(exp_fl));
        end
        @(negedge clk);
        if (h) or16 = 1'b1; else or32 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        or32 = 1'b0;
        check({name, " idle after consume"}, 32'(get_ir(h)), 32'd1);
    endtask

    // Start an op, reset the block partway through DIVIDE, then verify recovery
    task automatic reset_mid_divide(input bit h, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] exp_res, input int exp_lat);
        @(negedge clk);
        if (h) begin
            a16 = a[15:0]; b16 = b[15:0]; iv16 = 1'b1;
        end else begin
            a32 = a; b32 = b; iv32 = 1'b1;
        end
        @(posedge clk); #1;
        iv16 = 1'b0;
        iv32 = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset in_ready", 32'(get_ir(h)), 32'd1);
        check("midreset out_valid", 32'(get_ov(h)), 32'd0);
        check("midreset result", get_res(h), 32'd0);
        check("midreset flags", 32'(get_fl(h)), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(h, a, b, exp_res, 4'h0, exp_lat, "after midreset");
    endtask

    vec_t vecs[8];

    initial begin
        logic [31:0] ra, rb, rres;
        logic [3:0]  rfl;
        bit          rspec;

        vecs[0] = '{1'b0, 32'h40866666, 32'h404CCCCC, 32'h3FA80000, 4'h0, 28};
        vecs[1] = '{1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'h0, 28};
        vecs[2] = '{1'b0, 32'hC0CCCCCC, 32'hBF000000, 32'h414CCCCC, 4'h0, 28};
        vecs[3] = '{1'b0, 32'h40C00000, 32'h00000000, 32'h7F800000, 4'h4, 0};
        vecs[4] = '{1'b0, 32'h00000000, 32'h00000000, 32'h7FC00000, 4'h8, 0};
        vecs[5] = '{1'b0, 32'h7F7FFFFF, 32'h3E800000, 32'h7F800000, 4'h2, 28};
        vecs[6] = '{1'b0, 32'h00800000, 32'h40000000, 32'h00000000, 4'h1, 28};
        vecs[7] = '{1'b1, 32'h00004200, 32'h00003C00, 32'h00004200, 4'h0, 15};

        rst_n = 1'b0;
        iv32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0;
        iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(ir32), 32'd1);
        check("reset out_valid", 32'(ov32), 32'd0);
        check("reset result", res32, 32'd0);
        check("reset flags", 32'(fl32), 32'd0);
        check("reset16 result", 32'(res16), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].h, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl,
                  vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Backpressure: hold out_ready low in DONE with stray in_valid
        @(negedge clk);
        a32 = 32'h3F800000; b32 = 32'h40400000; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        for (int n = 0; n < 100 && !ov32; n++) begin
            @(posedge clk); #1;
        end
        check("bp out_valid", 32'(ov32), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a32 = 32'h40866666; b32 = 32'h404CCCCC; iv32 = 1'b1;
            @(posedge clk); #1;
            check("bp hold result", res32, 32'h3EAAAAAB);
            check("bp hold flags", 32'(fl32), 32'd0);
            check("bp hold in_ready", 32'(ir32), 32'd0);
            check("bp hold out_valid", 32'(ov32), 32'd1);
        end
        @(negedge clk);
        iv32 = 1'b0;
        or32 = 1'b1;
        @(posedge clk); #1;
        or32 = 1'b0;
        check("bp release in_ready", 32'(ir32), 32'd1);
        check("bp release out_valid", 32'(ov32), 32'd0);
        @(posedge clk); #1;
        check("bp no stray accept", 32'(ir32), 32'd1);

        // Asynchronous reset partway through an iteration, both formats
        reset_mid_divide(1'b0, 32'h40866666, 32'h404CCCCC, 32'h3FA80000, 28);
        do_op(1'b1, 32'h00004200, 32'h00003C00, 32'h00004200, 4'h0, 15, "h prime");
        reset_mid_divide(1'b1, 32'h00004200, 32'h00003C00, 32'h00004200, 15);

        // Randomized single precision
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 0) begin
                ra[30:23] = 8'($urandom_range(100, 154));
                rb[30:23] = 8'($urandom_range(100, 154));
            end
            ref_div(8, 23, ra, rb, rres, rfl, rspec);
            do_op(1'b0, ra, rb, rres, rfl, rspec ? 0 : 28, $sformatf("rnd32_%0d", i));
        end

        // Randomized half precision
        for (int i = 0; i < 100; i++) begin
            ra = {16'h0, 16'($urandom)};
            rb = {16'h0, 16'($urandom)};
            if (i % 2 == 0) begin
                ra[14:10] = 5'($urandom_range(8, 22));
                rb[14:10] = 5'($urandom_range(8, 22));
            end
            ref_div(5, 10, ra, rb, rres, rfl, rspec);
            do_op(1'b1, ra, rb, rres, rfl, rspec ? 0 : 15, $sformatf("rnd16_%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
